// File: rtl/fpu_add_sub_normalizer_pkg.sv
// Shared fp16 field widths, the packed fp16 type and small result constructors
// used by the add/sub normalizer and its rounding helper.
package fpu_add_sub_normalizer_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;
    localparam int MANT_W = 14;
    localparam int SIG_W  = FRAC_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    function automatic fp16_t fp16_inf(input logic sign);
        fp16_t r;
        r.sign = sign;
        r.exp  = EXP_MAX;
        r.frac = '0;
        return r;
    endfunction

    function automatic fp16_t fp16_zero(input logic sign);
        fp16_t r;
        r.sign = sign;
        r.exp  = '0;
        r.frac = '0;
        return r;
    endfunction

endpackage

// File: rtl/fpu_add_sub_normalizer_rne.sv
// Round-to-nearest-even increment of the 11-bit significand; purely combinational.
// A carry out means the significand wrapped to 1.0 of the next binade.
module fpu_add_sub_normalizer_rne
    import fpu_add_sub_normalizer_pkg::*;
(
    input  logic [SIG_W-1:0] mant_i,
    input  logic             guard_i,
    input  logic             rs_i,
    output logic [SIG_W-1:0] mant_o,
    output logic             carry_o
);

    logic inc;

    assign inc = guard_i & (rs_i | mant_i[0]);
    assign {carry_o, mant_o} = {1'b0, mant_i} + {{SIG_W{1'b0}}, inc};

endmodule

// File: rtl/fpu_add_sub_normalizer.sv
// Normalizes and rounds a raw adder sum into fp16, one item in flight, one shift per cycle.
// Result and flags are held in DONE until out_ready; nothing is accepted outside IDLE.
module fpu_add_sub_normalizer
    import fpu_add_sub_normalizer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              sticky_in,
    output logic              out_valid,
    input  logic              out_ready,
    output fp16_t             result,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic              sticky_q, sticky_d;
    fp16_t             result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              inexact_q, inexact_d;

    logic [SIG_W-1:0]  rnd_mant;
    logic              rnd_carry;
    logic [EXP_W-1:0]  exp_inc;
    logic              inexact_w;

    fpu_add_sub_normalizer_rne u_rne (
        .mant_i  (mant_q[12:2]),
        .guard_i (mant_q[1]),
        .rs_i    (mant_q[0] | sticky_q),
        .mant_o  (rnd_mant),
        .carry_o (rnd_carry)
    );

    assign exp_inc   = exp_q + 5'd1;
    assign inexact_w = mant_q[1] | mant_q[0] | sticky_q;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = sign_in;
                    // Subnormal inputs share the scale of exponent 1.
                    exp_d    = (exp_in == '0) ? 5'd1 : exp_in;
                    mant_d   = mant_in;
                    sticky_d = sticky_in;
                    state_d  = S_NORM;
                end
            end
            S_NORM: begin
                if (mant_q == '0 && !sticky_q) begin
                    result_d    = fp16_zero(sign_q);
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                    state_d     = S_DONE;
                end else if (exp_q == EXP_MAX) begin
                    result_d    = fp16_inf(sign_q);
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b1;
                    state_d     = S_DONE;
                end else if (mant_q[13]) begin
                    mant_d   = {1'b0, mant_q[13:1]};
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_inc;
                end else if (!mant_q[12] && exp_q > 5'd1) begin
                    mant_d = {mant_q[12:0], 1'b0};
                    exp_d  = exp_q - 5'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                inexact_d  = inexact_w;
                overflow_d = 1'b0;
                if (rnd_carry && exp_inc == EXP_MAX) begin
                    result_d   = fp16_inf(sign_q);
                    overflow_d = 1'b1;
                end else if (rnd_carry) begin
                    result_d.sign = sign_q;
                    result_d.exp  = exp_inc;
                    result_d.frac = '0;
                end else begin
                    // A hidden bit of 0 can only occur at exponent 1, i.e. a subnormal.
                    result_d.sign = sign_q;
                    result_d.exp  = rnd_mant[FRAC_W] ? exp_q : {EXP_W{1'b0}};
                    result_d.frac = rnd_mant[FRAC_W-1:0];
                end
                underflow_d = inexact_w & (result_d.exp == '0);
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fpu_add_sub_normalizer.sv
// Scoreboarded bench for fpu_add_sub_normalizer: directed corner vectors, a reset
// pulse mid-normalization, then randomized raw sums against an arithmetic fp16 model.
module tb_fpu_add_sub_normalizer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [13:0] mant_in;
    logic        sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_w;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    fpu_add_sub_normalizer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .sticky_in (sticky_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result_w),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stall  = 0;
    bit   seen   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Value-level model: pick the whole normalization shift at once, then round.
    function automatic exp_t model(input bit s, input bit [4:0] e_in, input bit [13:0] m, input bit st);
        exp_t        x;
        int          e, p, k, sig, rnd;
        bit [13:0]   n;
        bit          sn, g, r;
        x = '0;
        e = (e_in == 0) ? 1 : int'(e_in);
        if (m == 0 && !st) begin
            x.res = {s, 15'h0};
            x.lat = 2;
            return x;
        end
        if (e == 31) begin
            x.res = {s, 5'h1f, 10'h0};
            x.ovf = 1; x.inx = 1; x.lat = 2;
            return x;
        end
        p = -1;
        for (int i = 0; i < 14; i++) if (m[i]) p = i;
        if (p == 13) begin
            n = m >> 1; sn = st | m[0]; e = e + 1; k = 1;
            if (e == 31) begin
                x.res = {s, 5'h1f, 10'h0};
                x.ovf = 1; x.inx = 1; x.lat = 3;
                return x;
            end
        end else begin
            if (p < 0) k = e - 1;
            else k = (12 - p < e - 1) ? 12 - p : e - 1;
            n = m << k; sn = st; e = e - k;
        end
        sig = int'(n[12:2]);
        g   = n[1];
        r   = n[0] | sn;
        x.inx = g | r;
        rnd = sig + ((g && (r || (sig % 2 == 1))) ? 1 : 0);
        if (rnd == 2048) begin
            e = e + 1;
            rnd = 1024;
        end
        if (e == 31) begin
            x.res = {s, 5'h1f, 10'h0};
            x.ovf = 1;
        end else begin
            x.res = {s, (rnd >= 1024) ? 5'(e) : 5'd0, 10'(rnd % 1024)};
        end
        x.unf = x.inx && (x.res[14:10] == 5'd0);
        x.lat = 3 + k;
        return x;
    endfunction

    task automatic issue(input bit s, input bit [4:0] e, input bit [13:0] m, input bit st);
        exp_t x;
        int   waitc;
        x = model(s, e, m, st);
        @(negedge clock);
        sign_in = s; exp_in = e; mant_in = m; sticky_in = st; in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clock);
            waitc++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
            in_valid = 1'b0;
            return;
        end
        x.acc = cyc + 1;
        q.push_back(x);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Monitor: compares every DONE cycle (so holding is checked too) and retires on handshake.
    initial begin
        exp_t cur;
        out_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) continue;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    cur = q[0];
                    if (!seen) begin
                        seen = 1;
                        check("latency", cyc - cur.acc + 1, cur.lat);
                    end
                    check("result_flags", {13'h0, result_w, overflow, underflow, inexact},
                          {13'h0, cur.res, cur.ovf, cur.unf, cur.inx});
                    check("in_ready_in_done", in_ready, 0);
                end
            end else if (q.size() > 0 && (cyc - q[0].acc) > 40) begin
                check("out_valid_timeout", 0, 1);
                void'(q.pop_front());
                seen = 0;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                if (out_valid) stall--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                seen = 0;
            end
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0;
        exp_in = '0; mant_in = '0; sticky_in = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {result_w, overflow, underflow, inexact}, 0);
        reset_n = 1'b1;

        issue(0, 5'h0F, 14'b01_0000000000_00, 0);
        issue(0, 5'h0F, 14'b10_0000000000_00, 0);
        issue(0, 5'h1E, 14'b10_0000000000_00, 0);
        issue(0, 5'h0F, 14'b00_0100000000_00, 0);
        issue(0, 5'h01, 14'b00_0000000001_00, 0);
        issue(0, 5'h0F, 14'b01_0000000001_10, 0);
        issue(0, 5'h0F, 14'b01_0000000000_10, 0);
        issue(0, 5'h0F, 14'b01_1111111111_11, 0);
        issue(0, 5'h00, 14'b00_0000000000_01, 1);
        issue(1, 5'h1F, 14'b00_0001000000_00, 0);
        issue(0, 5'h1E, 14'b01_1111111111_11, 0);
        wait_drain();

        // Zero result held for five cycles while a second request waits outside.
        stall = 5;
        issue(1, 5'h0F, 14'h0000, 0);
        issue(0, 5'h10, 14'b01_1000000000_00, 0);
        wait_drain();

        // Six-shift item interrupted by reset while normalizing.
        issue(0, 5'h0F, 14'h0040, 0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", {result_w, overflow, underflow, inexact}, 0);
        void'(q.pop_back());
        @(negedge clock);
        reset_n = 1'b1;
        issue(0, 5'h0F, 14'h0040, 0);
        issue(0, 5'h0F, 14'h0001, 0);
        wait_drain();

        for (int i = 0; i < 300; i++) begin
            bit [13:0] m;
            m = 14'($urandom) >> $urandom_range(0, 13);
            issue(1'($urandom), 5'($urandom_range(0, 31)), m, 1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_add_sub_normalizer.md
FPU_ADD_SUB_NORMALIZER -- requirements
Module: fpuAddSubNormalizer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports clock and reset_n.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  raw adder result presented.
REQ-005 in_ready  output  1  block can accept.
REQ-006 sign_in  input  1  result sign.
REQ-007 exp_in  input  5  biased exponent of the larger operand.
REQ-008 mant_in  input  14  raw sum: [13] carry, [12] hidden, [11:2] fraction, [1] guard, [0] round.
REQ-009 sticky_in  input  1  OR of bits shifted out during alignment.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer accepts.
REQ-012 result  output  16 (fp16_t)  packed, rounded fp16.
REQ-013 overflow, underflow, inexact  output  1 each  IEEE flags for result.

Function
REQ-014 SHALL implement the FSM IDLE -> NORM -> ROUND -> DONE -> IDLE; one item in flight.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer (in_valid & in_ready) SHALL register all inputs and enter NORM.
REQ-016 exp_in==0 SHALL be loaded as internal exponent 1 (subnormal convention).
REQ-017 NORM, per cycle, in priority order:
  (a) mant==0 & sticky==0: result {sign,0,0}, all flags 0, go DONE.
  (b) exponent==31: result {sign,11111,0}, overflow=1, inexact=1, go DONE.
  (c) mant[13]==1: shift right 1 with mant[0] ORed into sticky, exp+1; if exp becomes 31 -> overflow path next cycle.
  (d) mant[12]==0 & exp>1: shift left 1, zero fill, exp-1.
  (e) otherwise go ROUND.
REQ-018 ROUND SHALL use round-to-nearest-even: lsb=mant[2], guard=mant[1], rs=mant[0]|sticky; increment the 11-bit {hidden,fraction} iff guard & (rs | lsb).
REQ-019 Increment carry-out SHALL yield fraction 0, exp+1; exp reaching 31 SHALL give infinity with overflow=1.
REQ-020 Exponent field SHALL be 0 when hidden bit is 0 after rounding, else internal exp; a subnormal rounding into hidden=1 SHALL give field 1.
REQ-021 inexact = guard|round|sticky at ROUND entry; underflow = inexact & result exponent field 0.
REQ-022 DONE: out_valid=1; result and flags SHALL be stable until out_ready=1, then IDLE next edge; no accept in DONE.
REQ-023 Latency from accept edge to out_valid: 3 cycles normalized, +1 per NORM shift; max 15.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=16'h0000, all flags 0, including mid-NORM/ROUND/DONE; in-flight item discarded.

Structure
REQ-025 fp16_t and field widths (EXP_W=5, FRAC_W=10, BIAS=15, EXP_MAX=31) SHALL come from the shared fpu library/constants; FSM state enum local.
REQ-026 One sub-module, fpuRoundNearestEven (combinational: 11-bit mantissa, guard, round/sticky -> rounded mantissa, carry), is natural.

Verification
REQ-027 sign 0, exp 0x0F, mant 01_0000000000_00 -> result 16'h3C00, flags 0, out_valid 3 cycles after accept.
REQ-028 exp 0x0F, mant 10_0000000000_00 -> 16'h4000, latency 4; exp 0x1E same mant -> 16'h7C00, overflow=1.
REQ-029 exp 0x0F, mant 00_0100000000_00 -> 16'h3400 after 2 left shifts, latency 5; exp 0x01, mant 00_0000000001_00 -> 16'h0001 (subnormal, no shift), underflow=0.
REQ-030 Ties: mant 01_0000000001_10 -> 16'h3C02, inexact=1; mant 01_0000000000_10 -> 16'h3C00, inexact=1; mant 01_1111111111_11 -> 16'h4000.
REQ-031 sign 1, mant 0, sticky 0 -> 16'h8000; out_ready low 5 cycles -> result stable, in_ready=0, second in_valid ignored.
REQ-032 reset_n pulsed low during NORM of a 6-shift input -> out_valid=0, result 0, in_ready=1 immediately; next input processed correctly.
